sobel_line_buffer: RTL and testbench

SOBEL_LINE_BUFFER -- requirements
Module: sobel_line_buffer

---
 rtl/sobel_line_buffer.sv | 130 +++++++++++++
 tb/tb_sobel_line_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
//   Line buffer that feeds a vertical pixel column to a 3x3 (or taller)
//   window operator. It stores NUM_LINES previous image lines. For every
//   accepted pixel it returns that pixel together with the pixels at the
//   same column 1..NUM_LINES lines above it. The result appears one cycle
//   after the accept.
//
// Parameters
//   DATA_WD   pixel width in bits
//   ADDR_WD   column address width
//   LINE_WD   pixels per image line (2 .. 2**ADDR_WD)
//   NUM_LINES stored previous lines (1 .. 4)
//
// Ports
//   clk_i        clock; all logic on the rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous frame restart; wins over valid_i
//   pix_i        incoming pixel in raster order
//   valid_i      pix_i accepted this cycle (no backpressure)
//   taps_o       vertical column; slice k = pixel k lines above, slice 0 at LSBs
//   col_o        column index of taps_o
//   valid_o      taps_o / col_o valid this cycle
//   win_valid_o  valid_o and all upper taps hold data of the current frame
module sobel_line_buffer #(
  parameter int DATA_WD   = 8,
  parameter int ADDR_WD   = 8,
  parameter int LINE_WD   = 220,
  parameter int NUM_LINES = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [DATA_WD-1:0]               pix_i,
  input  logic                             valid_i,
  output logic [(NUM_LINES+1)*DATA_WD-1:0] taps_o,
  output logic [ADDR_WD-1:0]               col_o,
  output logic                             valid_o,
  output logic                             win_valid_o
);

  localparam int                  R_WD   = $clog2(NUM_LINES + 1);
  localparam logic [R_WD-1:0]     R_FULL = R_WD'(NUM_LINES);
  localparam logic [ADDR_WD-1:0]  X_LAST = ADDR_WD'(LINE_WD - 1);

  // Row-fill count saturates once every stored line holds frame data.
  function automatic logic [R_WD-1:0] sat_inc(input logic [R_WD-1:0] v);
    return (v == R_FULL) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: accept, column / row-fill counters, memory read ----
  logic               accept_p0;
  logic [ADDR_WD-1:0] col_p0;
  logic [R_WD-1:0]    fill_p0;

  assign accept_p0 = valid_i & ~clear_i;

  // ---- stage p1: registered read data, delayed write, outputs ----
  logic [DATA_WD-1:0]                 pix_p1;
  logic [ADDR_WD-1:0]                 col_p1;
  logic                               vld_p1;
  logic                               win_p1;
  logic [NUM_LINES:0][DATA_WD-1:0]    tap_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_p0  <= '0;
      fill_p0 <= '0;
      vld_p1  <= 1'b0;
      win_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      win_p1 <= accept_p0 && (fill_p0 == R_FULL);
      if (clear_i) begin
        col_p0  <= '0;
        fill_p0 <= '0;
      end else if (valid_i) begin
        if (col_p0 == X_LAST) begin
          col_p0  <= '0;
          fill_p0 <= sat_inc(fill_p0);
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
      end
    end
  end

  // Output registers only move on an accept, so they hold while valid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_p1 <= '0;
      col_p1 <= '0;
    end else if (accept_p0) begin
      pix_p1 <= pix_i;
      col_p1 <= col_p0;
    end
  end

  assign tap_p1[0] = pix_p1;

  // Line k is rewritten one cycle after the accept with what was tap k,
  // so the column shifts up by one line per image row. A write and a read
  // never hit the same column in the same cycle: the next accept is always
  // at a different column, or comes after a clear/reset.
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    logic [DATA_WD-1:0] mem [LINE_WD];
    logic [DATA_WD-1:0] rd_p1;

    always_ff @(posedge clk_i) begin
      if (vld_p1) begin
        mem[col_p1] <= tap_p1[k];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_p1 <= '0;
      end else if (accept_p0) begin
        rd_p1 <= mem[col_p0];
      end
    end

    assign tap_p1[k+1] = rd_p1;
  end

  assign taps_o      = tap_p1;
  assign col_o       = col_p1;
  assign valid_o     = vld_p1;
  assign win_valid_o = win_p1;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Testbench for sobel_line_buffer (LINE_WD=4, NUM_LINES=2, DATA_WD=8).
// The reference model keeps every pixel accepted since the last frame start.
// The expected tap k of pixel n is the pixel n - k*LINE_WD of that history.
module tb_sobel_line_buffer;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int LW = 4;
  localparam int NL = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   clear_i;
  logic [DW-1:0]          pix_i;
  logic                   valid_i;
  logic [(NL+1)*DW-1:0]   taps_o;
  logic [AW-1:0]          col_o;
  logic                   valid_o;
  logic                   win_valid_o;

  sobel_line_buffer #(
    .DATA_WD  (DW),
    .ADDR_WD  (AW),
    .LINE_WD  (LW),
    .NUM_LINES(NL)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .pix_i      (pix_i),
    .valid_i    (valid_i),
    .taps_o     (taps_o),
    .col_o      (col_o),
    .valid_o    (valid_o),
    .win_valid_o(win_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  // reference model state
  logic [DW-1:0] hist [$];
  logic [DW-1:0] exp_tap   [NL+1];
  bit            exp_known [NL+1];
  logic [AW-1:0] exp_col;
  bit            exp_valid;
  bit            exp_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid_o", {63'd0, valid_o}, {63'd0, exp_valid});
    chk("win_valid_o", {63'd0, win_valid_o}, {63'd0, exp_win});
    chk("col_o", {62'd0, col_o}, {62'd0, exp_col});
    for (int k = 0; k <= NL; k++) begin
      if (exp_known[k]) begin
        chk($sformatf("tap%0d", k), {56'd0, taps_o[k*DW +: DW]}, {56'd0, exp_tap[k]});
      end
    end
  endtask

  task automatic reset_model();
    hist.delete();
    exp_valid = 1'b0;
    exp_win   = 1'b0;
    exp_col   = '0;
    for (int k = 0; k <= NL; k++) begin
      exp_tap[k]   = '0;
      exp_known[k] = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, take the edge, then compare.
  task automatic step(input bit v, input logic [DW-1:0] p, input bit clr);
    int n;
    valid_i = v;
    pix_i   = p;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    if (clr) begin
      hist.delete();
      exp_valid = 1'b0;
      exp_win   = 1'b0;
    end else if (v) begin
      n = hist.size();
      hist.push_back(p);
      exp_valid = 1'b1;
      exp_win   = (n >= NL * LW);
      exp_col   = AW'(n % LW);
      for (int k = 0; k <= NL; k++) begin
        if (n >= k * LW) begin
          exp_tap[k]   = hist[n - k * LW];
          exp_known[k] = 1'b1;
        end else begin
          exp_known[k] = 1'b0;
        end
      end
    end else begin
      exp_valid = 1'b0;
      exp_win   = 1'b0;
    end
    if (valid_o === 1'b1) vcount++;
    check_outputs();
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  initial begin
    int accepted;
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    pix_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_model();
    check_outputs();
    rst_ni = 1'b1;

    // continuous stream 1..12
    for (int i = 1; i <= 9; i++) step(1'b1, DW'(i), 1'b0);
    chk("p9_taps", {40'd0, taps_o}, 64'h010509);
    chk("p9_win", {63'd0, win_valid_o}, 64'd1);
    for (int i = 10; i <= 12; i++) step(1'b1, DW'(i), 1'b0);
    chk("p12_taps", {40'd0, taps_o}, 64'h04080C);
    chk("p12_col", {62'd0, col_o}, 64'd3);

    // same stream with a gap every other cycle
    step(1'b0, '0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, DW'(i), 1'b0);
      step(1'b0, 8'hA5, 1'b0);
    end

    // clear together with pixel 6
    step(1'b0, '0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 8'd6, 1'b1);
    for (int i = 7; i <= 15; i++) step(1'b1, DW'(i), 1'b0);

    // asynchronous reset mid-line after pixel 7
    step(1'b0, '0, 1'b1);
    for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b0);
    rst_ni = 1'b0;
    #1;
    reset_model();
    check_outputs();
    chk("rst_taps", {40'd0, taps_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs();
    rst_ni = 1'b1;
    for (int i = 1; i <= 9; i++) step(1'b1, DW'(i), 1'b0);
    chk("rst_p9_taps", {40'd0, taps_o}, 64'h010509);
    for (int i = 10; i <= 12; i++) step(1'b1, DW'(i), 1'b0);
    chk("rst_p12_taps", {40'd0, taps_o}, 64'h04080C);

    // 20 lines of random pixels with random stalls
    step(1'b0, '0, 1'b1);
    vcount   = 0;
    accepted = 0;
    while (accepted < 20 * LW) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, DW'($urandom), 1'b0);
        accepted++;
      end else begin
        step(1'b0, DW'($urandom), 1'b0);
      end
    end
    chk("rand_win_sat", {63'd0, win_valid_o}, 64'd1);
    step(1'b0, '0, 1'b0);
    chk("rand_vcount", 64'(vcount), 64'(accepted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
